// File: rtl/vga_timing_decoder.sv
// Recovers pixel/line counters from raw VGA sync inputs and tracks lock to the
// configured timing, flagging and counting every loss of lock.
module vga_timing_decoder #(
    parameter int H_TOTAL      = 1056,
    parameter int H_SYNC_START = 840,
    parameter int V_TOTAL      = 628,
    parameter int V_SYNC_START = 601,
    parameter int TIMEOUT      = 2112
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_cnt
);

    // state    | meaning
    // SEARCH   | waiting for two consecutive lines of H_TOTAL cycles
    // H_LOCK   | line length confirmed, waiting for a frame of V_TOTAL lines
    // LOCKED   | counters trusted; any misplaced edge or timeout drops lock
    typedef enum logic [1:0] {SEARCH, H_LOCK, LOCKED} state_t;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC = 11'(H_SYNC_START);
    localparam logic [10:0] H_PRE  = 11'(H_SYNC_START - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_SYNC = 11'(V_SYNC_START);
    localparam logic [10:0] V_PRE  = 11'(V_SYNC_START - 1);
    localparam logic [10:0] V_LEN  = 11'(V_TOTAL);
    localparam logic [10:0] MAX11  = 11'h7FF;
    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    state_t        state, state_nxt;
    logic          h_edge, v_edge, h_wrap;
    logic          line_good, frame_good, bad_h, bad_v, timeout, lose_lock;
    logic [10:0]   line_len, frame_len;
    logic          line_valid, frame_valid, prev_line_good;
    logic [TW-1:0] tmr;

    // The delayed sync outputs double as the edge-detect history registers.
    assign h_edge     = hsync_in & ~hsync_out;
    assign v_edge     = vsync_in & ~vsync_out;
    assign h_wrap     = !h_edge && (hcount_out == H_LAST);
    assign line_good  = line_valid && (line_len == H_LAST);
    assign frame_good = frame_valid && (frame_len == V_LEN);
    assign timeout    = (tmr == TMR_ONE) && !h_edge;
    assign bad_h      = h_edge && (hcount_out != H_PRE);
    assign bad_v      = v_edge && (vcount_out != V_PRE) && (vcount_out != V_SYNC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            hsync_out <= hsync_in;
            hblnk_out <= hblnk_in;
            vsync_out <= vsync_in;
            vblnk_out <= vblnk_in;
            if (h_edge)
                hcount_out <= H_SYNC;
            else if (hcount_out == H_LAST)
                hcount_out <= '0;
            else
                hcount_out <= hcount_out + 11'd1;
            if (v_edge)
                vcount_out <= V_SYNC;
            else if (h_wrap)
                vcount_out <= (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        end
    end

    // Line meter holds cycles since the last hsync edge minus one; the first
    // edge after reset only arms it, since the span before it is not a line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_len       <= '0;
            line_valid     <= 1'b0;
            prev_line_good <= 1'b0;
            tmr            <= '0;
            frame_len      <= '0;
            frame_valid    <= 1'b0;
        end else begin
            if (h_edge) begin
                line_len       <= '0;
                line_valid     <= 1'b1;
                prev_line_good <= line_good;
                tmr            <= TMR_LOAD;
            end else begin
                if (line_len != MAX11)
                    line_len <= line_len + 11'd1;
                if (tmr != '0)
                    tmr <= tmr - TMR_ONE;
            end
            if (v_edge) begin
                frame_len   <= {10'd0, h_edge};
                frame_valid <= 1'b1;
            end else if (h_edge && (frame_len != MAX11)) begin
                frame_len <= frame_len + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (h_edge && line_good && prev_line_good)
                    state_nxt = H_LOCK;
            end
            H_LOCK: begin
                if (timeout || (h_edge && !line_good))
                    state_nxt = SEARCH;
                else if (v_edge && frame_good)
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                if (timeout || bad_h || bad_v)
                    state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        locked    = (state == LOCKED);
        lose_lock = (state == LOCKED) && (state_nxt == SEARCH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= lose_lock;
            if (lose_lock && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
